uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Transmit scheduler for the console UART. It generates the 16x baud tick and shares a single `uart_tx` between two byte requesters: requester 0 is the CPU teleprinter and requester 1 is the debug monitor. Arbitration is round-robin with line locking, so lines from the two sources never interleave mid-line. It also sequences each character into the transmitter's holding register with a `tx_write`/`tx_rdy` handshake.

## Interface
- `X16_DIV`, default 326: clocks per `mclkx16` tick. 50 MHz / (9600 × 16) ≈ 326. Legal range 2..65535.
- `LOCK_TICKS`, default 4096: `mclkx16` ticks of owner inactivity before the line lock is released. 0 disables locking.
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `mclkx16`  out  1  one-`clk` pulse every `X16_DIV` clocks; drives `uart_tx.mclkx16`.
- `req0_valid`  in  1  requester 0 has a byte.
- `req0_data`  in  8  requester 0 byte.
- `req0_ready`  out  1  requester 0 byte accepted this cycle if `req0_valid` is high.
- `req1_valid`  in  1  requester 1 has a byte.
- `req1_data`  in  8  requester 1 byte.
- `req1_ready`  out  1  requester 1 byte accepted this cycle if `req1_valid` is high.
- `tx_write`  out  1  write strobe to `uart_tx`.
- `tx_data`  out  8  byte to `uart_tx`.
- `tx_rdy`  in  1  `uart_tx` holding register free.
- `owner`  out  1  requester that was granted last.
- `locked`  out  1  line lock held by `owner`.

## Operation
- Divider: 16-bit counter runs 0..`X16_DIV`-1 and wraps. `mclkx16` is high for the one cycle where count == `X16_DIV`-1. It runs continuously from reset release.
- FSM states: IDLE, WRITE, SETTLE, WAIT.
- IDLE: a requester is selected as follows.
  - If `locked`, only `owner` is eligible.
  - Otherwise the single valid requester is selected.
  - If both are valid, the requester that is not `owner` is selected (round-robin).
- `reqK_ready` = `run` & IDLE & `tx_rdy` & (K is the selected requester). `run` is a flag set on the first `clk` edge after `rst_n` rises.
  - The ready outputs are combinational from registered state and `tx_rdy`.
  - At most one ready is high in any cycle.
- Accept (valid & ready):
  - data is captured in the 8-bit hold register;
  - `owner` becomes K;
  - the FSM goes to WRITE.
- WRITE: `tx_write` = 1 for exactly one cycle, `tx_data` = hold; next state SETTLE.
- SETTLE: one cycle, `tx_rdy` is ignored, because `uart_tx` drops `tx_rdy` one cycle after the write. Next state is IDLE, or WAIT if a second byte is pending (see Configuration).
- WAIT: stay until `tx_rdy` = 1, then go to WRITE with the pending byte.
- Line lock:
  - An accept with data[6:0] ≠ 7'h0A sets `locked`.
  - An accept with data[6:0] == 7'h0A (LF, either parity) clears `locked`.
  - The timeout counter (16-bit) clears on every accept. While `locked` and in IDLE, it increments on each `mclkx16`. When it reaches `LOCK_TICKS`, `locked` clears.
  - With `LOCK_TICKS` = 0, `locked` stays 0.
- Simultaneous events:
  - An accept and a timeout in the same cycle: the accept wins and the lock is kept or set.
  - A valid from the non-owner while locked is held off; its ready stays 0.
- Reset asserted mid-operation: all state clears immediately. Any byte in hold or pending is dropped. Requesters must re-present after reset.

## Timing
- Reset values:
  - `mclkx16`, `tx_write`, `tx_data` (8'h00), `owner`, `locked`, `run`, ready outputs: all 0;
  - FSM state IDLE; divider and timeout counters 0.
- Accept at cycle N gives `tx_write` at N+1, SETTLE at N+2, and IDLE at N+3.
- The minimum accept-to-accept spacing is 3 cycles, and longer if `tx_rdy` is low.
- `tx_data` is registered and holds its value until the next WRITE.
- The first `mclkx16` pulse comes `X16_DIV` clocks after reset release.

## Configuration
- `UART_TX_SCHED_CRLF_EN` defined:
  - An accepted LF (data[6:0] == 7'h0A) is preceded by a CR.
  - The CR byte is {data[7], 7'h0D}, so it carries the LF's parity bit.
  - The CR is sent only if that owner's previous accepted byte was not a CR.
  - Sequence: WRITE(CR), SETTLE, WAIT, WRITE(LF), SETTLE, IDLE.
  - One "last byte was CR" flag per requester, cleared on reset.
- Not defined: bytes pass through unchanged, WAIT is unreachable, and no CR logic is built.

## Test plan
- Reset release, `X16_DIV` = 4: `mclkx16` pulses at cycles 4, 8, 12 after reset. All outputs are 0 during reset.
- Requester 0 sends 8'hC1 with `tx_rdy` = 1: `req0_ready` is high at accept cycle N. `tx_write` = 1 with `tx_data` = 8'hC1 at N+1 only. `req0_ready` stays low at N+1 and N+2.
- Both requesters valid, unlocked (`LOCK_TICKS` = 0), `owner` = 0: requester 1 is granted first, then the grants alternate 0, 1, 0.
- Requester 0 sends 8'h48 then holds valid low while requester 1 is valid: `req1_ready` stays 0 until requester 0 sends 8'h8A. Alternatively, after `LOCK_TICKS` = 3 ticks with no owner accept, `locked` falls and requester 1 is granted.
- With `UART_TX_SCHED_CRLF_EN`, requester 0 sends 8'h8A: `tx_data` shows 8'h8D, then 8'h8A, with the LF write waiting for `tx_rdy`. Sending 8'h8D, 8'h8A produces exactly two writes.
- Drop `rst_n` while in WAIT: `tx_write` never fires for the pending LF. After release the FSM is in IDLE and `locked` = 0.

Source files
------------

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Transmit scheduler for the console UART. It has four jobs:
//   - it generates the 16x baud tick for uart_tx;
//   - it arbitrates one uart_tx between the CPU teleprinter (requester 0) and
//     the debug monitor (requester 1), round-robin with line locking, so that
//     lines from the two sources never interleave;
//   - it feeds each byte into the transmitter holding register using a
//     tx_write / tx_rdy handshake;
//   - optionally, it inserts a CR in front of each LF.
//
// Parameters:
//   X16_DIV     clocks per mclkx16 tick (2..65535)
//   LOCK_TICKS  mclkx16 ticks of owner inactivity before the line lock is
//               released; 0 disables locking
//
// Ports:
//   i_clk, i_rst_n                 system clock, async active-low reset
//   o_mclkx16                      one-clock tick every X16_DIV clocks
//   i_req0_valid/_data, o_req0_ready   requester 0 (CPU teleprinter)
//   i_req1_valid/_data, o_req1_ready   requester 1 (debug monitor)
//   o_tx_write, o_tx_data          write strobe and byte to uart_tx
//   i_tx_rdy                       uart_tx holding register free
//   o_owner                        requester granted last
//   o_locked                       line lock held by o_owner
//
// Build option:
//   UART_TX_SCHED_CRLF_EN  when defined, each accepted LF is preceded by a CR
//                          that carries the LF's parity bit. The CR is skipped
//                          when that requester's previous byte was already a CR.
module uart_tx_sched #(
  parameter int unsigned X16_DIV    = 326,
  parameter int unsigned LOCK_TICKS = 4096
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic       o_mclkx16,
  input  logic       i_req0_valid,
  input  logic [7:0] i_req0_data,
  output logic       o_req0_ready,
  input  logic       i_req1_valid,
  input  logic [7:0] i_req1_data,
  output logic       o_req1_ready,
  output logic       o_tx_write,
  output logic [7:0] o_tx_data,
  input  logic       i_tx_rdy,
  output logic       o_owner,
  output logic       o_locked
);

  localparam logic [15:0] DIV_LAST  = 16'(X16_DIV - 1);
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_TICKS - 1);
  localparam bit          LOCK_EN   = (LOCK_TICKS != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_SETTLE,
    ST_WAIT
  } state_t;

  state_t      r_state;
  logic [15:0] r_divCount;
  logic [15:0] r_lockCount;
  logic        r_run;
  logic        r_owner;
  logic        r_locked;
  logic        r_txWrite;
  logic [7:0]  r_hold;

  logic        w_mclkx16;
  logic        w_sel;
  logic        w_selValid;
  logic        w_grant;
  logic [7:0]  w_acceptData;
  logic        w_isLf;

`ifdef UART_TX_SCHED_CRLF_EN
  logic [7:0]  r_pend;
  logic        r_pendValid;
  logic [1:0]  r_lastCr;
  logic        w_isCr;
`endif

  // Baud tick divider. The counter runs freely from reset release, and the
  // tick is decoded from the counter's last value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_divCount <= 16'd0;
    end else if (r_divCount == DIV_LAST) begin
      r_divCount <= 16'd0;
    end else begin
      r_divCount <= r_divCount + 16'd1;
    end
  end

  assign w_mclkx16 = (r_divCount == DIV_LAST);

  // Requester selection.
  // - While the line is locked, only the owner may go.
  // - Otherwise, when both requesters want the line, the one that did not go
  //   last is chosen.
  always_comb begin
    w_sel      = 1'b0;
    w_selValid = 1'b0;
    if (r_locked) begin
      w_sel      = r_owner;
      w_selValid = r_owner ? i_req1_valid : i_req0_valid;
    end else if (i_req0_valid && i_req1_valid) begin
      w_sel      = ~r_owner;
      w_selValid = 1'b1;
    end else if (i_req1_valid) begin
      w_sel      = 1'b1;
      w_selValid = 1'b1;
    end else if (i_req0_valid) begin
      w_sel      = 1'b0;
      w_selValid = 1'b1;
    end
  end

  // The ready signal is qualified by the selected requester's valid, so a
  // raised ready always means an accept in that cycle.
  assign w_grant      = r_run && (r_state == ST_IDLE) && i_tx_rdy && w_selValid;
  assign o_req0_ready = w_grant && !w_sel;
  assign o_req1_ready = w_grant && w_sel;

  assign w_acceptData = w_sel ? i_req1_data : i_req0_data;
  assign w_isLf       = (w_acceptData[6:0] == 7'h0A);
`ifdef UART_TX_SCHED_CRLF_EN
  assign w_isCr       = (w_acceptData[6:0] == 7'h0D);
`endif

  // The run flag, the owner, and the line lock with its inactivity timeout.
  // An accept always takes precedence over a timeout in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run       <= 1'b0;
      r_owner     <= 1'b0;
      r_locked    <= 1'b0;
      r_lockCount <= 16'd0;
    end else begin
      r_run <= 1'b1;
      if (w_grant) begin
        r_owner     <= w_sel;
        r_locked    <= LOCK_EN && !w_isLf;
        r_lockCount <= 16'd0;
      end else if (r_locked && (r_state == ST_IDLE) && w_mclkx16) begin
        if (r_lockCount == LOCK_LAST) begin
          r_locked    <= 1'b0;
          r_lockCount <= 16'd0;
        end else begin
          r_lockCount <= r_lockCount + 16'd1;
        end
      end
    end
  end

  // Write sequencer.
  // - An accepted byte is loaded into the hold register, and the one-cycle
  //   write strobe is raised.
  // - SETTLE then masks tx_rdy for one cycle, because uart_tx only drops
  //   tx_rdy one cycle after it sees the write.
  // - With CR insertion, the LF is parked in r_pend and sent from WAIT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_hold      <= 8'h00;
      r_txWrite   <= 1'b0;
`ifdef UART_TX_SCHED_CRLF_EN
      r_pend      <= 8'h00;
      r_pendValid <= 1'b0;
      r_lastCr    <= 2'b00;
`endif
    end else begin
      r_txWrite <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_state   <= ST_WRITE;
            r_txWrite <= 1'b1;
`ifdef UART_TX_SCHED_CRLF_EN
            r_lastCr[w_sel] <= w_isCr;
            if (w_isLf && !r_lastCr[w_sel]) begin
              r_hold      <= {w_acceptData[7], 7'h0D};
              r_pend      <= w_acceptData;
              r_pendValid <= 1'b1;
            end else begin
              r_hold <= w_acceptData;
            end
`else
            r_hold <= w_acceptData;
`endif
          end
        end
        ST_WRITE: begin
          r_state <= ST_SETTLE;
        end
        ST_SETTLE: begin
`ifdef UART_TX_SCHED_CRLF_EN
          r_state <= r_pendValid ? ST_WAIT : ST_IDLE;
`else
          r_state <= ST_IDLE;
`endif
        end
        ST_WAIT: begin
`ifdef UART_TX_SCHED_CRLF_EN
          if (i_tx_rdy) begin
            r_state     <= ST_WRITE;
            r_txWrite   <= 1'b1;
            r_hold      <= r_pend;
            r_pendValid <= 1'b0;
          end
`else
          r_state <= ST_IDLE;
`endif
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_mclkx16  = w_mclkx16;
  assign o_tx_write = r_txWrite;
  assign o_tx_data  = r_hold;
  assign o_owner    = r_owner;
  assign o_locked   = r_locked;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched
// Self-checking bench for uart_tx_sched with X16_DIV = 4 and LOCK_TICKS = 3.
// The expected outputs come from a timeline model of the scheduler. The model
// tracks when the next write is due, when the scheduler becomes free again,
// and a tick tally for the line lock. Directed scenarios cover the documented
// cases, and a randomized run follows them.
module tb_uart_tx_sched;

  localparam int DIV  = 4;
  localparam int LOCK = 3;
`ifdef UART_TX_SCHED_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       mclkx16;
  logic       req0Valid = 1'b0;
  logic [7:0] req0Data = 8'h00;
  logic       req0Ready;
  logic       req1Valid = 1'b0;
  logic [7:0] req1Data = 8'h00;
  logic       req1Ready;
  logic       txWrite;
  logic [7:0] txData;
  logic       txRdy = 1'b0;
  logic       owner;
  logic       locked;

  always #5 clk = ~clk;

  uart_tx_sched #(.X16_DIV(DIV), .LOCK_TICKS(LOCK)) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .o_mclkx16    (mclkx16),
    .i_req0_valid (req0Valid),
    .i_req0_data  (req0Data),
    .o_req0_ready (req0Ready),
    .i_req1_valid (req1Valid),
    .i_req1_data  (req1Data),
    .o_req1_ready (req1Ready),
    .o_tx_write   (txWrite),
    .o_tx_data    (txData),
    .i_tx_rdy     (txRdy),
    .o_owner      (owner),
    .o_locked     (locked)
  );

  int checkCount = 0;
  int passCount  = 0;

  // Timeline model state. cyc counts clock edges since reset release.
  int         cyc;
  bit         mOwner;
  bit         mLocked;
  int         mTicks;
  int         mIdleAt;
  int         mWriteAt;
  logic [7:0] mWriteData;
  logic [7:0] mTxData;
  bit         mLfPending;
  logic [7:0] mLfData;
  int         mLfEarliest;
  bit [1:0]   mLastCr;
  bit         mAccept;
  bit         mAcceptK;

  // Observation tallies used by the directed scenarios.
  int writesSeen;
  int pulsesSeen;
  int ready0Seen;
  int ready1Seen;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, actual, expected);
    end
  endtask

  task automatic modelReset();
    cyc         = 0;
    mOwner      = 1'b0;
    mLocked     = 1'b0;
    mTicks      = 0;
    mIdleAt     = 0;
    mWriteAt    = -1;
    mWriteData  = 8'h00;
    mTxData     = 8'h00;
    mLfPending  = 1'b0;
    mLfData     = 8'h00;
    mLfEarliest = 0;
    mLastCr     = 2'b00;
    mAccept     = 1'b0;
    mAcceptK    = 1'b0;
  endtask

  // One clock cycle. The task is entered at a falling edge; it drives the
  // inputs, checks the outputs against the model, advances the model across
  // the next rising edge, and returns at the following falling edge.
  task automatic applyStimulus(input bit v0, input logic [7:0] d0, input bit v1,
                               input logic [7:0] d1, input bit rdy);
    bit         idle;
    bit         sel;
    bit         selValid;
    bit         tick;
    logic [7:0] d;
    req0Valid = v0;
    req0Data  = d0;
    req1Valid = v1;
    req1Data  = d1;
    txRdy     = rdy;
    #1;
    if (cyc == mWriteAt) mTxData = mWriteData;
    idle     = !mLfPending && (cyc >= mIdleAt);
    tick     = (cyc % DIV) == (DIV - 1);
    sel      = 1'b0;
    selValid = 1'b0;
    if (mLocked) begin
      sel      = mOwner;
      selValid = mOwner ? v1 : v0;
    end else if (v0 && v1) begin
      sel      = !mOwner;
      selValid = 1'b1;
    end else if (v0 || v1) begin
      sel      = v1;
      selValid = 1'b1;
    end
    mAccept  = (cyc >= 1) && idle && rdy && selValid;
    mAcceptK = sel;

    checkOutput("mclkx16", 32'(mclkx16), 32'(tick));
    checkOutput("req0_ready", 32'(req0Ready), 32'(mAccept && !sel));
    checkOutput("req1_ready", 32'(req1Ready), 32'(mAccept && sel));
    checkOutput("tx_write", 32'(txWrite), 32'(cyc == mWriteAt));
    checkOutput("tx_data", 32'(txData), 32'(mTxData));
    checkOutput("owner", 32'(owner), 32'(mOwner));
    checkOutput("locked", 32'(locked), 32'(mLocked));
    if (txWrite === 1'b1) writesSeen++;
    if (mclkx16 === 1'b1) pulsesSeen++;
    if (req0Ready === 1'b1) ready0Seen++;
    if (req1Ready === 1'b1) ready1Seen++;

    if (mAccept) begin
      d        = sel ? d1 : d0;
      mOwner   = sel;
      mTicks   = 0;
      mLocked  = (LOCK != 0) && (d[6:0] != 7'h0A);
      mWriteAt = cyc + 1;
      if (CRLF && d[6:0] == 7'h0A && !mLastCr[sel]) begin
        mWriteData  = {d[7], 7'h0D};
        mLfPending  = 1'b1;
        mLfData     = d;
        mLfEarliest = cyc + 3;
      end else begin
        mWriteData = d;
        mIdleAt    = cyc + 3;
      end
      mLastCr[sel] = (d[6:0] == 7'h0D);
    end else if (idle && mLocked && tick) begin
      mTicks++;
      if (mTicks == LOCK) begin
        mLocked = 1'b0;
        mTicks  = 0;
      end
    end
    if (mLfPending && cyc >= mLfEarliest && rdy) begin
      mWriteAt   = cyc + 1;
      mWriteData = mLfData;
      mLfPending = 1'b0;
      mIdleAt    = cyc + 3;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic applyReset(input int n);
    rstN      = 1'b0;
    req0Valid = 1'b1;
    req1Valid = 1'b1;
    req0Data  = 8'hA5;
    req1Data  = 8'h5A;
    txRdy     = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      checkOutput("rst_mclkx16", 32'(mclkx16), 32'd0);
      checkOutput("rst_req0_ready", 32'(req0Ready), 32'd0);
      checkOutput("rst_req1_ready", 32'(req1Ready), 32'd0);
      checkOutput("rst_tx_write", 32'(txWrite), 32'd0);
      checkOutput("rst_tx_data", 32'(txData), 32'd0);
      checkOutput("rst_owner", 32'(owner), 32'd0);
      checkOutput("rst_locked", 32'(locked), 32'd0);
      @(negedge clk);
    end
    rstN = 1'b1;
    modelReset();
  endtask

  task automatic idleCycles(input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, rdy);
  endtask

  // Holds requester k valid with byte d until the model predicts that k is
  // accepted, or until maxCycles run out.
  task automatic sendByte(input bit k, input logic [7:0] d, input bit otherValid,
                          input logic [7:0] otherData, input int maxCycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < maxCycles && !done; i++) begin
      if (k) applyStimulus(otherValid, otherData, 1'b1, d, 1'b1);
      else   applyStimulus(1'b1, d, otherValid, otherData, 1'b1);
      done = mAccept && (mAcceptK == k);
    end
    checkOutput("send_accepted", 32'(done), 32'd1);
  endtask

  initial begin
    int  w0;
    int  waited;
    bit  granted;
    bit  v0;
    bit  v1;
    bit  rdy;
    logic [7:0] d0;
    logic [7:0] d1;

    modelReset();
    writesSeen = 0;
    pulsesSeen = 0;
    ready0Seen = 0;
    ready1Seen = 0;
    @(negedge clk);
    applyReset(3);

    // The divider ticks on the 4th, 8th and 12th clocks after release.
    pulsesSeen = 0;
    idleCycles(13, 1'b1);
    checkOutput("mclk_pulse_count", 32'(pulsesSeen), 32'd3);

    // A single byte from requester 0, followed by the lock hold-off.
    sendByte(1'b0, 8'hC1, 1'b0, 8'h00, 10);
    idleCycles(3, 1'b1);
    sendByte(1'b0, 8'h48, 1'b0, 8'h00, 10);
    ready1Seen = 0;
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, 1'b1, 8'h55, 1'b1);
    checkOutput("lock_holdoff", 32'(ready1Seen), 32'd0);
    sendByte(1'b0, 8'h8A, 1'b1, 8'h55, 10);
    sendByte(1'b1, 8'h55, 1'b0, 8'h00, 20);

    // Requester 1 now owns a locked line and falls silent. Requester 0 gets
    // in only after the inactivity timeout.
    granted = 1'b0;
    waited  = 0;
    for (int i = 0; i < 40 && !granted; i++) begin
      applyStimulus(1'b1, 8'h31, 1'b0, 8'h00, 1'b1);
      granted = (req0Ready === 1'b1);
      waited++;
    end
    checkOutput("timeout_grant", 32'(granted), 32'd1);
    checkOutput("timeout_not_early", 32'(waited >= 9), 32'd1);
    idleCycles(4, 1'b1);

    // Unlocked round-robin: both requesters send LFs and the grants alternate.
    ready0Seen = 0;
    ready1Seen = 0;
    for (int i = 0; i < 24; i++) applyStimulus(1'b1, 8'h0A, 1'b1, 8'h8A, 1'b1);
    checkOutput("rr_both_served", 32'(ready0Seen > 0 && ready1Seen > 0), 32'd1);
    // Locked round-robin: the owner keeps the line while it sends non-LF bytes.
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 8'h41, 1'b1, 8'h42, 1'b1);
    idleCycles(16, 1'b1);

    // An LF with tx_rdy low after the first write. CR insertion adds a write.
    w0 = writesSeen;
    sendByte(1'b0, 8'h8A, 1'b0, 8'h00, 30);
    idleCycles(5, 1'b0);
    idleCycles(5, 1'b1);
    checkOutput("lf_writes", 32'(writesSeen - w0), CRLF ? 32'd2 : 32'd1);
    w0 = writesSeen;
    sendByte(1'b0, 8'h8D, 1'b0, 8'h00, 10);
    sendByte(1'b0, 8'h8A, 1'b0, 8'h00, 10);
    idleCycles(6, 1'b1);
    checkOutput("cr_lf_writes", 32'(writesSeen - w0), 32'd2);

    // Reset during the LF wait. Nothing is sent after release.
    sendByte(1'b1, 8'h0A, 1'b0, 8'h00, 10);
    idleCycles(3, 1'b0);
    applyReset(2);
    w0 = writesSeen;
    idleCycles(10, 1'b1);
    checkOutput("post_reset_writes", 32'(writesSeen - w0), 32'd0);
    checkOutput("post_reset_locked", 32'(locked), 32'd0);

    // Randomized traffic against the model, with one reset in the middle.
    for (int i = 0; i < 800; i++) begin
      if (i == 400) applyReset(2);
      v0  = $urandom_range(0, 99) < 55;
      v1  = $urandom_range(0, 99) < 55;
      rdy = $urandom_range(0, 99) < 80;
      d0  = 8'($urandom);
      d1  = 8'($urandom);
      if ($urandom_range(0, 99) < 25) d0[6:0] = 7'h0A;
      else if ($urandom_range(0, 99) < 10) d0[6:0] = 7'h0D;
      if ($urandom_range(0, 99) < 25) d1[6:0] = 7'h0A;
      else if ($urandom_range(0, 99) < 10) d1[6:0] = 7'h0D;
      applyStimulus(v0, d0, v1, d1, rdy);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
